// File: rtl/dmrs_sched.sv
// DMRS symbol scheduler: walks one frame of OFDM symbols and enables the DMRS
// generator on the DMRS symbols selected by dmrs-AdditionalPosition.
module dmrs_sched #(
    parameter int unsigned SYMS_PER_SLOT   = 14,
    parameter int unsigned SLOTS_PER_FRAME = 10,
    parameter int unsigned DMRS_L0         = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] N_rb,
    input  logic [1:0] add_pos,
    input  logic       sym_tick,
    input  logic       DMRS_valid,
    output logic       dmrs_enable,
    output logic [3:0] N_slot_frame,
    output logic [6:0] N_rb_out,
    output logic [3:0] sym_idx,
    output logic [9:0] sample_cnt,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun,
    output logic       cfg_err
);

    typedef enum logic [1:0] {StIdle, StWaitSym, StGen} state_e;

    localparam logic [3:0] L0        = 4'(DMRS_L0);
    localparam logic [3:0] LastSym   = 4'(SYMS_PER_SLOT - 1);
    localparam logic [3:0] LastSlot  = 4'(SLOTS_PER_FRAME - 1);

    state_e     state_q, state_d;
    logic [6:0] n_rb_q, n_rb_d;
    logic [1:0] add_pos_q, add_pos_d;
    logic [3:0] slot_q, slot_d;
    logic [3:0] sym_q, sym_d;
    logic [9:0] cnt_q, cnt_d;
    logic       enable_q, enable_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       overrun_q, overrun_d;
    logic       cfg_err_q, cfg_err_d;

    logic       is_dmrs;
    logic       do_adv;
    logic [9:0] target;
    logic [9:0] cnt_inc;

    // 6 subcarriers per RB carry DMRS; 10 bits holds 6*127 = 762
    assign target  = {3'b000, n_rb_q} * 10'd6;
    assign cnt_inc = cnt_q + 10'd1;

    always_comb begin
        is_dmrs = 1'b0;
        unique case (add_pos_q)
            2'd0: is_dmrs = (sym_q == L0);
            2'd1: is_dmrs = (sym_q == L0) || (sym_q == 4'd11);
            2'd2: is_dmrs = (sym_q == L0) || (sym_q == 4'd7) || (sym_q == 4'd11);
            2'd3: is_dmrs = (sym_q == L0) || (sym_q == 4'd5) || (sym_q == 4'd8) ||
                            (sym_q == 4'd11);
            default: is_dmrs = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        n_rb_d    = n_rb_q;
        add_pos_d = add_pos_q;
        slot_d    = slot_q;
        sym_d     = sym_q;
        cnt_d     = cnt_q;
        enable_d  = enable_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        cfg_err_d = 1'b0;
        do_adv    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (N_rb != 7'd0) begin
                        n_rb_d    = N_rb;
                        add_pos_d = add_pos;
                        slot_d    = 4'd0;
                        sym_d     = 4'd0;
                        busy_d    = 1'b1;
                        state_d   = StWaitSym;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StWaitSym: begin
                if (sym_tick) begin
                    if (is_dmrs) begin
                        state_d  = StGen;
                        enable_d = 1'b1;
                        cnt_d    = 10'd0;
                    end else begin
                        do_adv = 1'b1;
                    end
                end
            end
            StGen: begin
                // A tick while generating is dropped; the position advances only on completion
                if (sym_tick) begin
                    overrun_d = 1'b1;
                end
                if (DMRS_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == target) begin
                        enable_d = 1'b0;
                        state_d  = StWaitSym;
                        do_adv   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_adv) begin
            if (sym_q == LastSym) begin
                sym_d = 4'd0;
                if (slot_q == LastSlot) begin
                    slot_d  = 4'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    slot_d = slot_q + 4'd1;
                end
            end else begin
                sym_d = sym_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            n_rb_q    <= 7'd0;
            add_pos_q <= 2'd0;
            slot_q    <= 4'd0;
            sym_q     <= 4'd0;
            cnt_q     <= 10'd0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_rb_q    <= n_rb_d;
            add_pos_q <= add_pos_d;
            slot_q    <= slot_d;
            sym_q     <= sym_d;
            cnt_q     <= cnt_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign dmrs_enable  = enable_q;
    assign N_slot_frame = slot_q;
    assign N_rb_out     = n_rb_q;
    assign sym_idx      = sym_q;
    assign sample_cnt   = cnt_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign overrun      = overrun_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_dmrs_sched.sv
// Directed bench for dmrs_sched; inputs change and outputs are sampled on the falling edge.
module tb_dmrs_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] N_rb = 7'd0;
    logic [1:0] add_pos = 2'd0;
    logic       sym_tick = 1'b0;
    logic       DMRS_valid = 1'b0;
    logic       dmrs_enable;
    logic [3:0] N_slot_frame;
    logic [6:0] N_rb_out;
    logic [3:0] sym_idx;
    logic [9:0] sample_cnt;
    logic       busy;
    logic       frame_done;
    logic       overrun;
    logic       cfg_err;

    int total = 0;
    int bad = 0;

    dmrs_sched dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .N_rb         (N_rb),
        .add_pos      (add_pos),
        .sym_tick     (sym_tick),
        .DMRS_valid   (DMRS_valid),
        .dmrs_enable  (dmrs_enable),
        .N_slot_frame (N_slot_frame),
        .N_rb_out     (N_rb_out),
        .sym_idx      (sym_idx),
        .sample_cnt   (sample_cnt),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: all entered and left at a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [6:0] nrb, input logic [1:0] ap);
        N_rb = nrb;
        add_pos = ap;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_tick();
        sym_tick = 1'b1;
        @(negedge clk);
        sym_tick = 1'b0;
    endtask

    task automatic send_valids(input int n);
        for (int i = 0; i < n; i++) begin
            DMRS_valid = 1'b1;
            @(negedge clk);
        end
        DMRS_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (dmrs_enable !== 1'b0) begin bad++; $display("FAIL reset_enable got=%b exp=0", dmrs_enable); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (N_rb_out !== 7'd0) begin bad++; $display("FAIL reset_nrb got=%0d exp=0", N_rb_out); end
        total++; if (sym_idx !== 4'd0) begin bad++; $display("FAIL reset_sym got=%0d exp=0", sym_idx); end
        total++; if (sample_cnt !== 10'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", sample_cnt); end
        total++; if ({frame_done, overrun, cfg_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {frame_done, overrun, cfg_err}); end
    endtask

    task automatic test_single();
        do_reset();
        do_start(7'd4, 2'd0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        total++; if (N_rb_out !== 7'd4) begin bad++; $display("FAIL single_nrb got=%0d exp=4", N_rb_out); end
        send_valids(3);
        total++; if (sample_cnt !== 10'd0) begin bad++; $display("FAIL single_valid_ignored got=%0d exp=0", sample_cnt); end
        do_tick();
        do_tick();
        total++; if (sym_idx !== 4'd2 || dmrs_enable !== 1'b0) begin bad++; $display("FAIL single_pre got sym=%0d en=%b exp sym=2 en=0", sym_idx, dmrs_enable); end
        do_tick();
        total++; if (dmrs_enable !== 1'b1 || sample_cnt !== 10'd0) begin bad++; $display("FAIL single_rise got en=%b cnt=%0d exp en=1 cnt=0", dmrs_enable, sample_cnt); end
        send_valids(23);
        total++; if (dmrs_enable !== 1'b1 || sample_cnt !== 10'd23) begin bad++; $display("FAIL single_mid got en=%b cnt=%0d exp en=1 cnt=23", dmrs_enable, sample_cnt); end
        send_valids(1);
        total++; if (dmrs_enable !== 1'b0 || sym_idx !== 4'd3) begin bad++; $display("FAIL single_fall got en=%b sym=%0d exp en=0 sym=3", dmrs_enable, sym_idx); end
    endtask

    task automatic test_frame();
        int windows = 0;
        int dones = 0;
        logic exp_en;
        do_reset();
        do_start(7'd1, 2'd3);
        for (int s = 0; s < 10; s++) begin
            for (int y = 0; y < 14; y++) begin
                total++;
                if (sym_idx !== 4'(y) || N_slot_frame !== 4'(s)) begin
                    bad++;
                    $display("FAIL frame_pos got slot=%0d sym=%0d exp slot=%0d sym=%0d", N_slot_frame, sym_idx, s, y);
                end
                exp_en = (y == 2 || y == 5 || y == 8 || y == 11);
                do_tick();
                if (frame_done === 1'b1) dones++;
                total++;
                if (dmrs_enable !== exp_en) begin
                    bad++;
                    $display("FAIL frame_enable slot=%0d sym=%0d got=%b exp=%b", s, y, dmrs_enable, exp_en);
                end
                if (dmrs_enable === 1'b1) begin
                    windows++;
                    send_valids(5);
                    total++;
                    if (N_slot_frame !== 4'(s) || N_rb_out !== 7'd1) begin
                        bad++;
                        $display("FAIL frame_stable got slot=%0d nrb=%0d exp slot=%0d nrb=1", N_slot_frame, N_rb_out, s);
                    end
                    send_valids(1);
                    total++;
                    if (dmrs_enable !== 1'b0) begin bad++; $display("FAIL frame_window_end got=%b exp=0", dmrs_enable); end
                end
            end
        end
        total++; if (windows != 40) begin bad++; $display("FAIL frame_windows got=%0d exp=40", windows); end
        total++; if (dones != 1) begin bad++; $display("FAIL frame_done_count got=%0d exp=1", dones); end
        total++; if (frame_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL frame_end got done=%b busy=%b exp done=1 busy=0", frame_done, busy); end
        total++; if (N_slot_frame !== 4'd0 || sym_idx !== 4'd0) begin bad++; $display("FAIL frame_wrap got slot=%0d sym=%0d exp 0 0", N_slot_frame, sym_idx); end
        @(negedge clk);
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL frame_done_pulse got=%b exp=0", frame_done); end
    endtask

    task automatic test_cfg_err();
        do_reset();
        do_start(7'd0, 2'd0);
        total++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL cfg_err_pulse got err=%b busy=%b exp err=1 busy=0", cfg_err, busy); end
        @(negedge clk);
        total++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL cfg_err_clear got err=%b busy=%b exp err=0 busy=0", cfg_err, busy); end
        do_start(7'd127, 2'd0);
        total++; if (busy !== 1'b1 || N_rb_out !== 7'd127 || cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_accept got busy=%b nrb=%0d err=%b exp 1 127 0", busy, N_rb_out, cfg_err); end
        do_tick(); do_tick(); do_tick();
        send_valids(761);
        total++; if (dmrs_enable !== 1'b1 || sample_cnt !== 10'd761) begin bad++; $display("FAIL cfg_max_mid got en=%b cnt=%0d exp en=1 cnt=761", dmrs_enable, sample_cnt); end
        send_valids(1);
        total++; if (dmrs_enable !== 1'b0 || sample_cnt !== 10'd762 || sym_idx !== 4'd3) begin bad++; $display("FAIL cfg_max_end got en=%b cnt=%0d sym=%0d exp 0 762 3", dmrs_enable, sample_cnt, sym_idx); end
    endtask

    task automatic test_overrun();
        do_reset();
        do_start(7'd4, 2'd0);
        do_tick(); do_tick(); do_tick();
        send_valids(3);
        do_tick();
        total++; if (overrun !== 1'b1 || sym_idx !== 4'd2 || sample_cnt !== 10'd3) begin bad++; $display("FAIL ovr_set got ovr=%b sym=%0d cnt=%0d exp 1 2 3", overrun, sym_idx, sample_cnt); end
        sym_tick = 1'b1;
        DMRS_valid = 1'b1;
        @(negedge clk);
        sym_tick = 1'b0;
        DMRS_valid = 1'b0;
        total++; if (sample_cnt !== 10'd4 || dmrs_enable !== 1'b1) begin bad++; $display("FAIL ovr_same_cycle got cnt=%0d en=%b exp cnt=4 en=1", sample_cnt, dmrs_enable); end
        send_valids(20);
        total++; if (dmrs_enable !== 1'b0 || sym_idx !== 4'd3 || overrun !== 1'b1) begin bad++; $display("FAIL ovr_done got en=%b sym=%0d ovr=%b exp 0 3 1", dmrs_enable, sym_idx, overrun); end
        do_tick();
        total++; if (sym_idx !== 4'd4 || overrun !== 1'b1) begin bad++; $display("FAIL ovr_hold got sym=%0d ovr=%b exp 4 1", sym_idx, overrun); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_start(7'd4, 2'd0);
        do_tick(); do_tick(); do_tick();
        send_valids(10);
        reset = 1'b1;
        DMRS_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        DMRS_valid = 1'b0;
        start = 1'b0;
        total++; if (dmrs_enable !== 1'b0 || busy !== 1'b0 || sample_cnt !== 10'd0) begin bad++; $display("FAIL rstmid_a got en=%b busy=%b cnt=%0d exp 0 0 0", dmrs_enable, busy, sample_cnt); end
        total++; if (N_rb_out !== 7'd0 || sym_idx !== 4'd0 || N_slot_frame !== 4'd0) begin bad++; $display("FAIL rstmid_b got nrb=%0d sym=%0d slot=%0d exp 0 0 0", N_rb_out, sym_idx, N_slot_frame); end
        do_start(7'd2, 2'd0);
        total++; if (busy !== 1'b1 || sym_idx !== 4'd0 || N_slot_frame !== 4'd0) begin bad++; $display("FAIL rstmid_restart got busy=%b sym=%0d slot=%0d exp 1 0 0", busy, sym_idx, N_slot_frame); end
        do_tick();
        total++; if (sym_idx !== 4'd1) begin bad++; $display("FAIL rstmid_tick got sym=%0d exp 1", sym_idx); end
    endtask

    // Continues from test_reset_mid: WAIT_SYM at symbol 1 with N_rb_out=2.
    task automatic test_start_busy();
        do_start(7'd9, 2'd3);
        total++; if (N_rb_out !== 7'd2 || cfg_err !== 1'b0) begin bad++; $display("FAIL busy_start_wait got nrb=%0d err=%b exp 2 0", N_rb_out, cfg_err); end
        do_start(7'd0, 2'd0);
        total++; if (cfg_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL busy_start_zero got err=%b busy=%b exp 0 1", cfg_err, busy); end
        do_tick();
        do_tick();
        total++; if (dmrs_enable !== 1'b1) begin bad++; $display("FAIL busy_gen_enter got=%b exp=1", dmrs_enable); end
        do_start(7'd50, 2'd1);
        total++; if (N_rb_out !== 7'd2 || cfg_err !== 1'b0 || dmrs_enable !== 1'b1) begin bad++; $display("FAIL busy_start_gen got nrb=%0d err=%b en=%b exp 2 0 1", N_rb_out, cfg_err, dmrs_enable); end
        send_valids(12);
        total++; if (dmrs_enable !== 1'b0 || sym_idx !== 4'd3) begin bad++; $display("FAIL busy_target got en=%b sym=%0d exp 0 3", dmrs_enable, sym_idx); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_frame();
        test_cfg_err();
        test_overrun();
        test_reset_mid();
        test_start_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmrs_sched.md
DMRS_SCHED -- requirements
Module: dmrs_sched

Interface
REQ-001 Parameters: SYMS_PER_SLOT, default 14, OFDM symbols per slot.
REQ-002 Parameters: SLOTS_PER_FRAME, default 10, slots per frame.
REQ-003 Parameters: DMRS_L0, default 2, first DMRS symbol index.
REQ-004 Ports: clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 Ports: reset, input, 1, synchronous, active-high.
REQ-006 Ports: start, input, 1, one-cycle request to process one frame.
REQ-007 Ports: N_rb, input, 7, allocated resource blocks; sampled on accepted start.
REQ-008 Ports: add_pos, input, 2, dmrs-AdditionalPosition (0..3); sampled on accepted start.
REQ-009 Ports: sym_tick, input, 1, one-cycle pulse marking the start of each OFDM symbol.
REQ-010 Ports: DMRS_valid, input, 1, sample strobe from the DMRS generator.
REQ-011 Ports: dmrs_enable, output, 1, enable to the DMRS generator; level-held for one DMRS symbol.
REQ-012 Ports: N_slot_frame, output, 4, current slot index to the generator.
REQ-013 Ports: N_rb_out, output, 7, latched N_rb to the generator.
REQ-014 Ports: sym_idx, output, 4, current symbol index within the slot.
REQ-015 Ports: sample_cnt, output, 10, DMRS samples received in the current symbol.
REQ-016 Ports: busy, output, 1, high from accepted start to frame end.
REQ-017 Ports: frame_done, output, 1, one-cycle pulse at frame end.
REQ-018 Ports: overrun, output, 1, sticky flag: sym_tick arrived during generation.
REQ-019 Ports: cfg_err, output, 1, one-cycle pulse: start rejected because N_rb == 0.

Function
REQ-020 States SHALL be IDLE, WAIT_SYM and GEN.
REQ-021 DMRS symbol set by add_pos:
  - 0: {2}
  - 1: {2,11}
  - 2: {2,7,11}
  - 3: {2,5,8,11}
  - Decoded from the latched add_pos.
REQ-022 IDLE, start with N_rb != 0:
  - latch N_rb and add_pos; N_slot_frame=0, sym_idx=0
  - busy=1 next cycle; go to WAIT_SYM.
REQ-023 IDLE, start with N_rb == 0: cfg_err pulses the next cycle; state unchanged.
REQ-024 start outside IDLE SHALL be ignored, with no flag.
REQ-025 WAIT_SYM, sym_tick on a DMRS symbol: go to GEN; dmrs_enable=1 and sample_cnt=0 the next cycle (1-cycle latency).
REQ-026 WAIT_SYM, sym_tick on a non-DMRS symbol: advance the symbol position (REQ-029).
REQ-027 GEN:
  - each DMRS_valid increments sample_cnt.
  - target = 6*N_rb_out, computed at 10-bit width with no overflow (max 762).
  - On the valid that makes the count equal target: dmrs_enable=0 next cycle, advance the symbol position, return to WAIT_SYM.
REQ-028 sym_tick in GEN: set overrun (sticky until reset), drop the tick; symbol position is unaffected.
REQ-029 Symbol advance:
  - sym_idx increments.
  - At SYMS_PER_SLOT-1 it wraps to 0 and N_slot_frame increments.
  - Advancing past the last symbol of the last slot: N_slot_frame=0, sym_idx=0, busy=0, frame_done=1 for one cycle, state IDLE.
REQ-030 DMRS_valid outside GEN SHALL be ignored.
REQ-031 N_slot_frame and N_rb_out SHALL hold stable throughout GEN.
REQ-032 sym_tick and DMRS_valid in the same cycle in GEN: count the sample, flag overrun.

Reset
REQ-033 On reset:
  - state IDLE
  - dmrs_enable=0, busy=0, frame_done=0, overrun=0, cfg_err=0
  - N_slot_frame=0, sym_idx=0, sample_cnt=0, N_rb_out=0
REQ-034 Reset SHALL take priority over all inputs in the same cycle, including mid-GEN. The generator enable drops the cycle after reset is asserted.

Verification
REQ-035 Single symbol:
  - Stimulus: N_rb=4, add_pos=0, start; ticks for symbols 0..2.
  - Response: dmrs_enable rises one cycle after the symbol-2 tick; falls after the 24th DMRS_valid; sym_idx=3.
REQ-036 Full frame:
  - Stimulus: add_pos=3, N_rb=1, 140 ticks, each DMRS symbol fed 6 valids.
  - Response: exactly 40 enable windows at symbols 2,5,8,11 of slots 0..9; frame_done once after the symbol-13 tick of slot 9; busy=0.
REQ-037 Config error:
  - Stimulus: start with N_rb=0.
  - Response: cfg_err pulse; busy stays 0.
  - Stimulus: a second start with N_rb=127.
  - Response: accepted; target 762 reached without wrap.
REQ-038 Overrun:
  - Stimulus: sym_tick during GEN at sample 3 of 24.
  - Response: overrun=1 and held; the symbol still completes at 24 samples; sym_idx is not double-advanced.
REQ-039 Reset mid-GEN:
  - Stimulus: reset at sample 10.
  - Response: next cycle all outputs at reset values; a subsequent start begins at slot 0, symbol 0.
REQ-040 Start while busy:
  - Stimulus: start pulses during WAIT_SYM and GEN with different N_rb.
  - Response: N_rb_out unchanged; no cfg_err.
